// File: rtl/axis_packet_fifo.sv
// AXI4-Stream synchronous FIFO carrying tlast alongside tdata. Supports cut-through or
// store-and-forward operation, drops oversize packets, and reports fill level and almost-full.
module axis_packet_fifo #(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int PACKET_MODE = 0,
    parameter int ALMOST_FULL = 12
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  almost_full,
    output logic                  pkt_drop
);
    localparam int                  DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] AF_LEVEL = (ADDR_WIDTH+1)'(ALMOST_FULL);

    typedef enum logic {ACCEPT, DROP} wr_state_e;

    wr_state_e           state_q, state_d;
    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] wr_commit_q, wr_commit_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] rd_limit;
    logic                en_q;
    logic                pkt_drop_q, pkt_drop_d;
    logic                full, wr_en, rd_en, drop_start, drop_end;
    logic [DATA_WIDTH:0] mem [DEPTH];

    assign full = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                  (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    // Store-and-forward only exposes beats up to the last committed tlast.
    assign rd_limit      = (PACKET_MODE != 0) ? wr_commit_q : wr_ptr_q;
    assign level         = wr_ptr_q - rd_ptr_q;
    assign almost_full   = (level >= AF_LEVEL);
    assign m_axis_tvalid = (rd_ptr_q != rd_limit);
    assign {m_axis_tlast, m_axis_tdata} = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
    assign rd_en         = m_axis_tvalid && m_axis_tready;
    assign pkt_drop      = (PACKET_MODE != 0) && pkt_drop_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ACCEPT;
        end else begin
            state_q <= state_d;
        end
    end

    // A full FIFO holding only one incomplete packet can never drain: abandon it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCEPT: if ((PACKET_MODE != 0) && full && (wr_commit_q == rd_ptr_q)) state_d = DROP;
            DROP:   if (s_axis_tvalid && s_axis_tlast) state_d = ACCEPT;
            default: state_d = ACCEPT;
        endcase
    end

    always_comb begin
        s_axis_tready = 1'b0;
        wr_en         = 1'b0;
        drop_start    = 1'b0;
        drop_end      = 1'b0;
        case (state_q)
            ACCEPT: begin
                s_axis_tready = en_q && !full;
                wr_en         = s_axis_tvalid && en_q && !full;
                drop_start    = (state_d == DROP);
            end
            DROP: begin
                s_axis_tready = 1'b1;
                drop_end      = s_axis_tvalid && s_axis_tlast;
            end
            default: ;
        endcase
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        rd_ptr_d    = rd_ptr_q;
        pkt_drop_d  = drop_end;
        if (drop_start) begin
            wr_ptr_d = wr_commit_q;
        end else if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (s_axis_tlast) wr_commit_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            en_q        <= 1'b0;
            pkt_drop_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            en_q        <= 1'b1;
            pkt_drop_q  <= pkt_drop_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Bench for axis_packet_fifo: one cut-through and one store-and-forward instance,
// scoreboard-checked data, level, flags and handshakes each cycle.
module tb_axis_packet_fifo;
    localparam int AW = 4, DW = 8, DEPTH = 16, AF = 12;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic [DW-1:0] s0_data = '0, s1_data = '0, m0_data, m1_data;
    logic s0_valid = 1'b0, s0_last = 1'b0, s1_valid = 1'b0, s1_last = 1'b0;
    logic m0_ready = 1'b0, m1_ready = 1'b0;
    logic s0_ready, s1_ready, m0_valid, m1_valid, m0_last, m1_last;
    logic af0, af1, drop0, drop1;
    logic [AW:0] level0, level1;

    axis_packet_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PACKET_MODE(0), .ALMOST_FULL(AF)) u_ct (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s0_data), .s_axis_tvalid(s0_valid), .s_axis_tlast(s0_last), .s_axis_tready(s0_ready),
        .m_axis_tdata(m0_data), .m_axis_tvalid(m0_valid), .m_axis_tlast(m0_last), .m_axis_tready(m0_ready),
        .level(level0), .almost_full(af0), .pkt_drop(drop0));

    axis_packet_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PACKET_MODE(1), .ALMOST_FULL(AF)) u_sf (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s1_data), .s_axis_tvalid(s1_valid), .s_axis_tlast(s1_last), .s_axis_tready(s1_ready),
        .m_axis_tdata(m1_data), .m_axis_tvalid(m1_valid), .m_axis_tlast(m1_last), .m_axis_tready(m1_ready),
        .level(level1), .almost_full(af1), .pkt_drop(drop1));

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       mr;
        logic       rdy;
        int         lvl;
    } vec_t;

    int n_cmp = 0, n_bad = 0;
    bit live = 0, dropping = 0;
    logic [8:0] sb0[$], sb1[$], pend[$];
    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic l,
                                input logic mr, input logic rdy, input int lvl);
        vec_t r;
        r.v = v; r.d = d; r.l = l; r.mr = mr; r.rdy = rdy; r.lvl = lvl;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: account for handshakes seen before the edge, then check post-edge state.
    task automatic step();
        bit wf0, rf0, wf1, rf1, drop_now, exp_pulse;
        logic [8:0] beat;
        int tot1;
        wf0 = s0_valid && s0_ready;
        rf0 = m0_valid && m0_ready;
        wf1 = s1_valid && s1_ready;
        rf1 = m1_valid && m1_ready;
        if (rf0) begin
            if (sb0.size() == 0) chk("ct_unexpected_beat", {m0_last, m0_data}, 9'h1ff);
            else begin beat = sb0.pop_front(); chk("ct_data", {m0_last, m0_data}, beat); end
        end
        if (wf0) sb0.push_back({s0_last, s0_data});
        drop_now = !dropping && (pend.size() == DEPTH) && (sb1.size() == 0);
        if (rf1) begin
            if (sb1.size() == 0) chk("sf_unexpected_beat", {m1_last, m1_data}, 9'h1ff);
            else begin beat = sb1.pop_front(); chk("sf_data", {m1_last, m1_data}, beat); end
        end
        exp_pulse = 0;
        if (drop_now) begin
            pend.delete();
            dropping = 1;
        end else if (wf1) begin
            if (dropping) begin
                if (s1_last) begin dropping = 0; exp_pulse = 1; end
            end else begin
                pend.push_back({s1_last, s1_data});
                if (s1_last) begin
                    foreach (pend[k]) sb1.push_back(pend[k]);
                    pend.delete();
                end
            end
        end
        @(posedge aclk);
        #1;
        tot1 = sb1.size() + pend.size();
        chk("ct_level", level0, sb0.size());
        chk("ct_tvalid", m0_valid, sb0.size() != 0);
        chk("ct_almost_full", af0, sb0.size() >= AF);
        chk("ct_pkt_drop", drop0, 0);
        chk("sf_level", level1, tot1);
        chk("sf_tvalid", m1_valid, sb1.size() != 0);
        chk("sf_almost_full", af1, tot1 >= AF);
        chk("sf_pkt_drop", drop1, exp_pulse);
        if (live) begin
            chk("ct_tready", s0_ready, sb0.size() < DEPTH);
            chk("sf_tready", s1_ready, dropping || (tot1 < DEPTH));
        end
    endtask

    task automatic send(input int which, input logic [7:0] d, input logic l);
        bit done = 0;
        for (int t = 0; t < 64 && !done; t++) begin
            if (which == 0) begin s0_valid = 1; s0_data = d; s0_last = l; done = s0_ready; end
            else begin s1_valid = 1; s1_data = d; s1_last = l; done = s1_ready; end
            step();
        end
        s0_valid = 0; s1_valid = 0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        m0_ready = 1; m1_ready = 1;
        for (int t = 0; t < 100 && (sb0.size() != 0 || sb1.size() != 0); t++) step();
        chk("drain_ct_level", level0, 0);
        chk("drain_sf_level", level1, pend.size());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 5; i++) tbl.push_back(mk(1'b1, 8'(i + 1), i == 4, 1'b1, 1'b1, 1));
        tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 0));
        for (int i = 0; i < 16; i++) tbl.push_back(mk(1'b1, 8'(i + 1), 1'b0, 1'b0, 1'b1, i + 1));
        tbl.push_back(mk(1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 16));
        tbl.push_back(mk(1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 15));
        tbl.push_back(mk(1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 16));
        for (int i = 0; i < 16; i++) tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, i != 0, 15 - i));

        #2;
        chk("rst_ct_tvalid", m0_valid, 0);
        chk("rst_ct_tready", s0_ready, 0);
        chk("rst_ct_level", level0, 0);
        chk("rst_ct_af", af0, 0);
        chk("rst_sf_tvalid", m1_valid, 0);
        chk("rst_sf_tready", s1_ready, 0);
        chk("rst_sf_drop", drop1, 0);
        @(posedge aclk);
        @(posedge aclk);
        #3 aresetn = 1'b1;
        #1 chk("rel_tready_low", s0_ready, 0);
        @(posedge aclk);
        #1 live = 1;
        chk("rel_ct_tready_up", s0_ready, 1);
        chk("rel_sf_tready_up", s1_ready, 1);

        // cut-through stream, fill to full, same-cycle read at full, wrap-around
        foreach (tbl[i]) begin
            s0_valid = tbl[i].v; s0_data = tbl[i].d; s0_last = tbl[i].l; m0_ready = tbl[i].mr;
            chk("tbl_tready", s0_ready, tbl[i].rdy);
            step();
            chk("tbl_level", level0, tbl[i].lvl);
        end
        s0_valid = 0;
        drain();

        // store-and-forward: held until tlast accepted
        m1_ready = 1;
        for (int i = 0; i < 3; i++) send(1, 8'(8'hA0 + i), 1'b0);
        chk("sf_hold_tvalid", m1_valid, 0);
        send(1, 8'hA3, 1'b1);
        chk("sf_first_tvalid", m1_valid, 1);
        chk("sf_first_data", m1_data, 8'hA0);
        drain();

        // oversize packet dropped, then a small packet passes
        for (int i = 0; i < 20; i++) send(1, 8'(8'h40 + i), i == 19);
        chk("oversize_pulse", drop1, 1);
        chk("oversize_level", level1, 0);
        step();
        for (int i = 0; i < 3; i++) send(1, 8'(8'hC0 + i), i == 2);
        drain();

        // committed packet queued, 13-beat packet fills FIFO without dropping
        m1_ready = 0;
        for (int i = 0; i < 4; i++) send(1, 8'(8'hD0 + i), i == 3);
        for (int i = 0; i < 12; i++) send(1, 8'(8'hE0 + i), 1'b0);
        chk("full_level", level1, 16);
        chk("full_tready", s1_ready, 0);
        step();
        chk("full_no_drop_level", level1, 16);
        m1_ready = 1;
        send(1, 8'hEC, 1'b1);
        drain();

        // asynchronous reset mid-packet
        m0_ready = 0;
        for (int i = 0; i < 7; i++) send(0, 8'(8'h30 + i), 1'b0);
        chk("pre_rst_level", level0, 7);
        #3 aresetn = 1'b0;
        #1;
        chk("async_rst_tvalid", m0_valid, 0);
        chk("async_rst_level", level0, 0);
        chk("async_rst_tready", s0_ready, 0);
        sb0.delete(); sb1.delete(); pend.delete(); dropping = 0; live = 0;
        @(posedge aclk);
        #3 aresetn = 1'b1;
        #1 chk("rst_rel_tready_low", s0_ready, 0);
        @(posedge aclk);
        #1 live = 1;
        chk("rst_rel_tready_up", s0_ready, 1);
        m0_ready = 1;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axis_packet_fifo.md
Name: axis_packet_fifo

Overview:
- AXI4-Stream synchronous FIFO with parametrised depth and width, and tlast carried alongside data.
- Runtime-static mode select:
  - cut-through: each beat is readable one cycle after it is written.
  - store-and-forward: beats are readable only once the packet's tlast has been written.
- In store-and-forward mode, a packet larger than the FIFO is dropped rather than deadlocking the FIFO.
- Exports fill level and threshold flags for upstream flow control. Sits between crossbar ingress and arbitration.

Parameters:
ADDR_WIDTH, 4, log2 of FIFO depth (DEPTH = 2**ADDR_WIDTH entries)
DATA_WIDTH, 8, tdata width in bits
PACKET_MODE, 0, 0 = cut-through, 1 = store-and-forward with oversize-packet drop
ALMOST_FULL, 12, level at or above which almost_full = 1 (must be at most DEPTH)

Ports:
aclk  input  1  clock; all logic on rising edge
aresetn  input  1  asynchronous active-low reset
s_axis_tdata  input  DATA_WIDTH  write data
s_axis_tvalid  input  1  write beat valid
s_axis_tlast  input  1  last beat of packet
s_axis_tready  output  1  FIFO accepts beat
m_axis_tdata  output  DATA_WIDTH  read data
m_axis_tvalid  output  1  read beat valid
m_axis_tlast  output  1  last beat of packet
m_axis_tready  input  1  downstream accepts beat
level  output  ADDR_WIDTH+1  entries stored (0..DEPTH), uncommitted beats included
almost_full  output  1  level >= ALMOST_FULL
pkt_drop  output  1  one-cycle pulse: oversize packet discarded

Behaviour:
- Reset is asynchronous on aresetn low and clears:
  - wr_ptr, wr_commit, rd_ptr and the ready-enable flop to 0;
  - the write FSM to ACCEPT;
  - pkt_drop to 0.
- Values while in reset: m_axis_tvalid = 0, s_axis_tready = 0, level = 0, almost_full = 0.
- s_axis_tready rises on the first aclk edge after aresetn deasserts. Reset mid-packet discards all contents; no partial packet survives.
- Pointers are ADDR_WIDTH+1 bits wide. The extra MSB is the wrap bit.
  - empty: wr_ptr == rd_ptr.
  - full: the MSBs differ and the lower bits are equal.
  - level = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1).
- Storage is {tlast, tdata} per entry. m_axis_tdata and m_axis_tlast are read combinationally from mem[rd_ptr].
- Write handshake:
  - A beat transfers when s_axis_tvalid && s_axis_tready.
  - In ACCEPT, s_axis_tready = enable && !full. It depends only on flops, never on s_axis_tvalid.
  - On transfer, the entry is written and wr_ptr increments.
  - If the beat has tlast, wr_commit <= wr_ptr + 1 on the same edge.
- Read limit:
  - PACKET_MODE = 0: limit = wr_ptr.
  - PACKET_MODE = 1: limit = wr_commit.
- m_axis_tvalid = (rd_ptr != limit). rd_ptr increments on m_axis_tvalid && m_axis_tready.
- Latency:
  - Cut-through: a beat accepted at edge N is presented in the cycle after edge N.
  - Store-and-forward: the first beat is presented in the cycle after the edge that accepts tlast.
  - There is no empty bypass.
- Simultaneous read and write:
  - Allowed when neither full nor empty; level is unchanged.
  - When full, a same-cycle read does not raise s_axis_tready; it rises the next cycle.
- Write FSM, which has effect only when PACKET_MODE = 1:
  - ACCEPT -> DROP when full && wr_commit == rd_ptr (the whole FIFO holds one incomplete packet). On that edge wr_ptr <= wr_commit, discarding the uncommitted beats.
  - In DROP: s_axis_tready = 1, beats are consumed but not stored, and wr_ptr is frozen.
  - DROP -> ACCEPT on an accepted beat with tlast. pkt_drop = 1 for the following cycle only.
  - If the DEPTH-th beat itself carries tlast, it commits normally and no drop occurs.
- Committed packets already queued are unaffected by a drop.
- almost_full is combinational from level.
- PACKET_MODE = 0 never enters DROP. pkt_drop is tied to 0.

Test Plan:
- Cut-through, ADDR_WIDTH=4: write 0x01..0x05 (tlast on 0x05) with m_axis_tready=1 -> 0x01 appears at m_axis one cycle after acceptance; all 5 beats in order; tlast only with 0x05; level returns to 0.
- Fill to full with m_axis_tready=0, 16 beats -> s_axis_tready=0 after beat 16, level=16, almost_full=1 from level 12. Then one read -> s_axis_tready=1 the next cycle; wrap-around write of 0x11 read back correctly after 0x10.
- PACKET_MODE=1: write a 4-beat packet at 1 beat/cycle -> m_axis_tvalid stays 0 until the cycle after tlast is accepted; the packet then streams out intact.
- PACKET_MODE=1, empty FIFO, 20-beat packet -> 16 stored; level returns to 0; beats 17..20 are consumed (tready=1); pkt_drop pulses once after beat 20. A subsequent 3-beat packet passes intact.
- PACKET_MODE=1: committed 4-beat packet queued, then a 13-beat packet -> no drop. First packet read, second completes, both delivered in order.
- Assert aresetn low mid-packet with level=7 -> m_axis_tvalid=0 and level=0 immediately (asynchronous). s_axis_tready=0 until the first edge after release.
